compute_tile_accel_wb_fabric: RTL and testbench
===============================================

// Module: compute_tile_accel_wb_fabric
// PURPOSE
// Wishbone fabric between the tile network adapter's Wishbone master and NR_ACCEL accelerator slaves (AES, hash, ...).
// Replaces the single hard-wired accelerator hookup: decodes the address into a per-accelerator window,
// runs one registered classic-cycle access at a time, and returns an error response for unmapped addresses
// and for slaves that do not answer. Keeps a saturating timeout count and the last faulting address for debug.
// PARAMETERS
// NR_ACCEL     2             number of accelerator slaves (1..16)
// ADDR_WIDTH   32            Wishbone address width
// DATA_WIDTH   32            Wishbone data width (multiple of 8)
// SEL_LSB      12            lowest address bit of the slave index; each window is 2**SEL_LSB bytes
// BASE_ADDR    32'h0000_0000 fabric base; bits [ADDR_WIDTH-1:SEL_LSB+SEL_W] must match
// TIMEOUT      255           cycles allowed in ACCESS before the access is aborted; 0 disables the timeout
// (derived) SEL_W = max(1, clog2(NR_ACCEL))
// PORTS
// clk             in   1                   system clock
// rst_sys_n       in   1                   synchronous reset, active-low
// wbs_adr_i       in   ADDR_WIDTH          request address (from the NA wbm_adr_o)
// wbs_dat_i       in   DATA_WIDTH          write data
// wbs_sel_i       in   DATA_WIDTH/8        byte selects
// wbs_we_i/cyc_i/stb_i  in  1 each         write enable, cycle, strobe
// wbs_dat_o       out  DATA_WIDTH          read data
// wbs_ack_o       out  1                   access completed
// wbs_err_o       out  1                   access failed
// acc_adr_o       out  NR_ACCEL*ADDR_WIDTH  per-slave address; slave k at [k*ADDR_WIDTH +: ADDR_WIDTH]
// acc_dat_o       out  NR_ACCEL*DATA_WIDTH  per-slave write data
// acc_sel_o       out  NR_ACCEL*DATA_WIDTH/8  per-slave byte selects
// acc_we_o/cyc_o/stb_o  out  NR_ACCEL      per-slave controls, one bit per slave
// acc_dat_i       in   NR_ACCEL*DATA_WIDTH  per-slave read data
// acc_ack_i/err_i in   NR_ACCEL            per-slave ack / error
// timeout_cnt_o   out  8                   saturating count of timed-out accesses
// last_err_adr_o  out  ADDR_WIDTH          address of the most recent error response (decode or timeout)
// BEHAVIOUR
// - Reset (rst_sys_n=0 at a clk edge): all outputs 0 and FSM to IDLE. Reset during ACCESS drops acc_cyc/stb at the next edge and produces no response.
// - FSM states: IDLE, ACCESS, RESP_ACK, RESP_ERR.
// - IDLE, when wbs_cyc_i & wbs_stb_i: latch adr, dat, sel and we. Slave index idx = adr[SEL_LSB +: SEL_W].
//   hit = (upper address bits == BASE_ADDR upper bits) && (idx < NR_ACCEL). On hit go to ACCESS; otherwise go to RESP_ERR.
// - ACCESS: only slave idx sees acc_cyc_o = acc_stb_o = 1, with the latched fields; all other slaves see 0. A wait counter starts at 0.
//   - acc_err_i[idx] -> RESP_ERR. acc_ack_i[idx] -> capture acc_dat_i[idx] and go to RESP_ACK. If err and ack arrive together, err wins.
//   - Ack and err from slaves other than idx are ignored.
//   - If the counter reaches TIMEOUT-1 with no response (TIMEOUT != 0): drop cyc/stb, increment timeout_cnt_o (saturates at 255), go to RESP_ERR.
//   - If wbs_cyc_i falls during ACCESS: drop the slave cyc/stb and return to IDLE with no response and no count change.
// - RESP_ACK: wbs_ack_o = 1 for exactly one cycle; wbs_dat_o = the captured data (also on writes). Then back to IDLE.
// - RESP_ERR: wbs_err_o = 1 for exactly one cycle; wbs_dat_o = 0; last_err_adr_o <= the latched address. Then back to IDLE.
// - wbs_ack_o and wbs_err_o are never high together; both are registered.
// - A strobe still high in the IDLE cycle after a response is treated as a new request.
// - Latency: request sampled at cycle 0, acc_stb at cycle 1, slave ack at cycle n>=1, wbs_ack_o at cycle n+1. A decode error is answered at cycle 1.
// - acc_adr_o carries the full latched address; it is not stripped.
// TESTING
// - NR_ACCEL=2: read adr 0x1004, slave1 acks at once with 0xCAFE0001 -> acc_stb_o=2'b10 at cycle 1, wbs_ack_o and wbs_dat_o=0xCAFE0001 at cycle 2, slave0 untouched.
// - NR_ACCEL=3: write adr 0x3000 (idx 3, unmapped) -> wbs_err_o at cycle 1, no acc_cyc_o ever, last_err_adr_o=0x3000, timeout_cnt_o unchanged.
// - TIMEOUT=8, slave0 never answers -> acc_cyc_o[0] high for 8 cycles, then wbs_err_o, timeout_cnt_o 0->1; 300 such accesses -> timeout_cnt_o=255.
// - Slave1 raises ack and err in the same cycle -> wbs_err_o only. A stray acc_ack_i[0] during a slave1 access -> ignored.
// - Master drops wbs_cyc_i at ACCESS cycle 3 -> acc_cyc_o=0 next edge, no wbs_ack_o/wbs_err_o; the next access completes normally.
// - rst_sys_n pulled low for 1 cycle mid-ACCESS -> all outputs 0 next edge, FSM IDLE, counters cleared; back-to-back accesses afterwards pass.

Source files
------------

// File: rtl/compute_tile_accel_wb_fabric.sv
// Wishbone fabric between the tile network adapter master and NR_ACCEL accelerator
// slaves. The address is decoded into one window per slave, and one registered
// classic-cycle access runs at a time. Unmapped addresses and silent slaves get an
// error response. A saturating timeout count and the last faulting address are kept
// for debug.
module compute_tile_accel_wb_fabric #(
  parameter int                    NR_ACCEL   = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEL_LSB    = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter int                    TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst_sys_n,
  input  logic [ADDR_WIDTH-1:0]            wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]          wbs_sel_i,
  input  logic                             wbs_we_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_stb_i,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic                             wbs_ack_o,
  output logic                             wbs_err_o,
  output logic [NR_ACCEL*ADDR_WIDTH-1:0]   acc_adr_o,
  output logic [NR_ACCEL*DATA_WIDTH-1:0]   acc_dat_o,
  output logic [NR_ACCEL*DATA_WIDTH/8-1:0] acc_sel_o,
  output logic [NR_ACCEL-1:0]              acc_we_o,
  output logic [NR_ACCEL-1:0]              acc_cyc_o,
  output logic [NR_ACCEL-1:0]              acc_stb_o,
  input  logic [NR_ACCEL*DATA_WIDTH-1:0]   acc_dat_i,
  input  logic [NR_ACCEL-1:0]              acc_ack_i,
  input  logic [NR_ACCEL-1:0]              acc_err_i,
  output logic [7:0]                       timeout_cnt_o,
  output logic [ADDR_WIDTH-1:0]            last_err_adr_o
);
  localparam int SEL_W     = (NR_ACCEL > 1) ? $clog2(NR_ACCEL) : 1;
  localparam int UPPER_LSB = SEL_LSB + SEL_W;
  localparam int SW        = DATA_WIDTH / 8;
  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_W:0] IDX_LIMIT = (SEL_W+1)'(NR_ACCEL);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP_ACK, RESP_ERR} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] lat_adr, lat_adr_next;
  logic [DATA_WIDTH-1:0] lat_dat, lat_dat_next;
  logic [SW-1:0]         lat_sel, lat_sel_next;
  logic                  lat_we, lat_we_next;
  logic [SEL_W-1:0]      idx, idx_next;
  logic [CW-1:0]         wait_cnt, wait_next;
  logic [NR_ACCEL-1:0]   cyc_next;
  logic                  ack_next, err_next;
  logic [DATA_WIDTH-1:0] rdat_next;
  logic [7:0]            tcnt_next;
  logic [ADDR_WIDTH-1:0] lerr_next;

  logic [SEL_W-1:0]      req_idx;
  logic                  hit;
  logic [NR_ACCEL-1:0]   req_onehot;
  logic                  slv_ack, slv_err;
  logic [DATA_WIDTH-1:0] slv_dat;

  // Decode the incoming request and pick out the response of the slave being accessed.
  always_comb begin
    req_idx    = wbs_adr_i[SEL_LSB +: SEL_W];
    hit        = (wbs_adr_i[ADDR_WIDTH-1:UPPER_LSB] == BASE_ADDR[ADDR_WIDTH-1:UPPER_LSB]) &&
                 ({1'b0, req_idx} < IDX_LIMIT);
    req_onehot = {NR_ACCEL{1'b0}};
    slv_ack    = 1'b0;
    slv_err    = 1'b0;
    slv_dat    = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NR_ACCEL; k++) begin
      req_onehot[k] = (req_idx == SEL_W'(k));
      slv_ack = slv_ack | (acc_ack_i[k] & (idx == SEL_W'(k)));
      slv_err = slv_err | (acc_err_i[k] & (idx == SEL_W'(k)));
      slv_dat = slv_dat | (acc_dat_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{idx == SEL_W'(k)}});
    end
  end

  // Next-state and next-output logic; responses are set up on entry to the RESP states.
  always_comb begin
    state_next   = state;
    lat_adr_next = lat_adr;
    lat_dat_next = lat_dat;
    lat_sel_next = lat_sel;
    lat_we_next  = lat_we;
    idx_next     = idx;
    wait_next    = wait_cnt;
    cyc_next     = acc_cyc_o;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    rdat_next    = {DATA_WIDTH{1'b0}};
    tcnt_next    = timeout_cnt_o;
    lerr_next    = last_err_adr_o;
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          lat_adr_next = wbs_adr_i;
          lat_dat_next = wbs_dat_i;
          lat_sel_next = wbs_sel_i;
          lat_we_next  = wbs_we_i;
          idx_next     = req_idx;
          wait_next    = {CW{1'b0}};
          if (hit) begin
            state_next = ACCESS;
            cyc_next   = req_onehot;
          end else begin
            state_next = RESP_ERR;
            err_next   = 1'b1;
            lerr_next  = wbs_adr_i;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (!wbs_cyc_i) begin
          // Master abandoned the cycle: release the slave silently.
          state_next = IDLE;
          cyc_next   = {NR_ACCEL{1'b0}};
        end else if (slv_err) begin
          state_next = RESP_ERR;
          cyc_next   = {NR_ACCEL{1'b0}};
          err_next   = 1'b1;
          lerr_next  = lat_adr;
        end else if (slv_ack) begin
          state_next = RESP_ACK;
          cyc_next   = {NR_ACCEL{1'b0}};
          ack_next   = 1'b1;
          rdat_next  = slv_dat;
        end else if ((TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1))) begin
          state_next = RESP_ERR;
          cyc_next   = {NR_ACCEL{1'b0}};
          err_next   = 1'b1;
          lerr_next  = lat_adr;
          if (timeout_cnt_o != 8'hFF) begin
            tcnt_next = timeout_cnt_o + 8'd1;
          end else begin
            tcnt_next = timeout_cnt_o;
          end
        end else begin
          wait_next = wait_cnt + CW'(1);
        end
      end
      RESP_ACK: state_next = IDLE;
      RESP_ERR: state_next = IDLE;
      default: begin
        state_next = IDLE;
        cyc_next   = {NR_ACCEL{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_sys_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latched request fields, wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_sys_n) begin
      lat_adr        <= {ADDR_WIDTH{1'b0}};
      lat_dat        <= {DATA_WIDTH{1'b0}};
      lat_sel        <= {SW{1'b0}};
      lat_we         <= 1'b0;
      idx            <= {SEL_W{1'b0}};
      wait_cnt       <= {CW{1'b0}};
      wbs_dat_o      <= {DATA_WIDTH{1'b0}};
      wbs_ack_o      <= 1'b0;
      wbs_err_o      <= 1'b0;
      acc_adr_o      <= {(NR_ACCEL*ADDR_WIDTH){1'b0}};
      acc_dat_o      <= {(NR_ACCEL*DATA_WIDTH){1'b0}};
      acc_sel_o      <= {(NR_ACCEL*SW){1'b0}};
      acc_we_o       <= {NR_ACCEL{1'b0}};
      acc_cyc_o      <= {NR_ACCEL{1'b0}};
      acc_stb_o      <= {NR_ACCEL{1'b0}};
      timeout_cnt_o  <= 8'd0;
      last_err_adr_o <= {ADDR_WIDTH{1'b0}};
    end else begin
      lat_adr        <= lat_adr_next;
      lat_dat        <= lat_dat_next;
      lat_sel        <= lat_sel_next;
      lat_we         <= lat_we_next;
      idx            <= idx_next;
      wait_cnt       <= wait_next;
      wbs_dat_o      <= rdat_next;
      wbs_ack_o      <= ack_next;
      wbs_err_o      <= err_next;
      acc_cyc_o      <= cyc_next;
      acc_stb_o      <= cyc_next;
      acc_we_o       <= cyc_next & {NR_ACCEL{lat_we_next}};
      timeout_cnt_o  <= tcnt_next;
      last_err_adr_o <= lerr_next;
      for (int k = 0; k < NR_ACCEL; k++) begin
        acc_adr_o[k*ADDR_WIDTH +: ADDR_WIDTH] <= cyc_next[k] ? lat_adr_next : {ADDR_WIDTH{1'b0}};
        acc_dat_o[k*DATA_WIDTH +: DATA_WIDTH] <= cyc_next[k] ? lat_dat_next : {DATA_WIDTH{1'b0}};
        acc_sel_o[k*SW +: SW]                 <= cyc_next[k] ? lat_sel_next : {SW{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_compute_tile_accel_wb_fabric.sv
// Directed bench for compute_tile_accel_wb_fabric with three slaves and an 8-cycle
// timeout. Single accesses come from a table. Master abort, saturation, reset in the
// middle of an access and back-to-back strobes are written out by hand.
module tb_compute_tile_accel_wb_fabric;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr, wb_wdat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_rdat;
  logic        wb_ack, wb_err;
  logic [95:0] acc_adr, acc_wdat, acc_rdat;
  logic [11:0] acc_sel;
  logic [2:0]  acc_we, acc_cyc, acc_stb, acc_ack, acc_err;
  logic [7:0]  tcnt;
  logic [31:0] lerr;

  int checks = 0;
  int errors = 0;

  compute_tile_accel_wb_fabric #(.NR_ACCEL(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_sys_n(rst_n),
    .wbs_adr_i(wb_adr), .wbs_dat_i(wb_wdat), .wbs_sel_i(wb_sel),
    .wbs_we_i(wb_we), .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb),
    .wbs_dat_o(wb_rdat), .wbs_ack_o(wb_ack), .wbs_err_o(wb_err),
    .acc_adr_o(acc_adr), .acc_dat_o(acc_wdat), .acc_sel_o(acc_sel),
    .acc_we_o(acc_we), .acc_cyc_o(acc_cyc), .acc_stb_o(acc_stb),
    .acc_dat_i(acc_rdat), .acc_ack_i(acc_ack), .acc_err_i(acc_err),
    .timeout_cnt_o(tcnt), .last_err_adr_o(lerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    int          rslave;    // slave that answers
    int          rdelay;    // cycles of cyc before it answers
    logic [1:0]  rkind;     // bit0 ack, bit1 err, 0 = silent
    logic [31:0] rdata;
    logic [2:0]  stray;     // acks from other slaves, held during the access
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_cycle; // cycle of the response, request sampled at cycle 0
    logic [2:0]  exp_stb;   // acc_stb_o at cycle 1
    logic [7:0]  exp_tcnt;
    logic [31:0] exp_lerr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = 32'h0; wb_wdat = 32'h0; wb_sel = 4'h0;
    acc_ack = 3'b000; acc_err = 3'b000;
    acc_rdat = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
  endtask

  // One access from an idle bus; slave responses are driven 1 time unit after each edge.
  task automatic run_access(input vec_t v, output logic got_ack, output logic got_err,
                            output logic [31:0] got_dat, output int got_cycle,
                            output logic [2:0] stb1, output logic [31:0] adr1,
                            output logic [31:0] dat1, output logic [3:0] sel1,
                            output logic [2:0] we1, output int cyc_cnt);
    int seen;
    @(posedge clk); #1;
    wb_adr = v.adr; wb_we = v.we; wb_wdat = v.wdat;
    wb_sel = v.we ? 4'h5 : 4'hF;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0; got_cycle = -1;
    stb1 = 3'b000; adr1 = 32'h0; dat1 = 32'h0; sel1 = 4'h0; we1 = 3'b000;
    cyc_cnt = 0; seen = 0;
    for (int c = 1; c <= 40 && got_cycle < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        stb1 = acc_stb;
        adr1 = acc_adr[v.rslave*32 +: 32];
        dat1 = acc_wdat[v.rslave*32 +: 32];
        sel1 = acc_sel[v.rslave*4 +: 4];
        we1  = acc_we;
      end
      if (acc_cyc != 3'b000) cyc_cnt++;
      if (wb_ack || wb_err) begin
        got_ack = wb_ack; got_err = wb_err; got_dat = wb_rdat; got_cycle = c;
      end
      acc_ack = v.stray;
      acc_err = 3'b000;
      if (acc_cyc[v.rslave]) begin
        if (seen == v.rdelay) begin
          acc_ack[v.rslave] = v.rkind[0];
          acc_err[v.rslave] = v.rkind[1];
          acc_rdat[v.rslave*32 +: 32] = v.rdata;
        end
        seen++;
      end
    end
    idle_inputs();
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    logic ga, ge; logic [31:0] gd, a1, d1; logic [3:0] s1; logic [2:0] st1, w1;
    int gc, cc;
    run_access(v, ga, ge, gd, gc, st1, a1, d1, s1, w1, cc);
    if (gc < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no response within 40 cycles", tag);
    end
    check({tag, "_ack"}, 64'(ga), 64'(v.exp_ack));
    check({tag, "_err"}, 64'(ge), 64'(v.exp_err));
    check({tag, "_dat"}, 64'(gd), 64'(v.exp_dat));
    check({tag, "_cycle"}, 64'(gc), 64'(v.exp_cycle));
    check({tag, "_stb1"}, 64'(st1), 64'(v.exp_stb));
    check({tag, "_cyc_cycles"}, 64'(cc), 64'((v.exp_stb != 3'b000) ? v.exp_cycle - 1 : 0));
    check({tag, "_tcnt"}, 64'(tcnt), 64'(v.exp_tcnt));
    check({tag, "_lerr"}, 64'(lerr), 64'(v.exp_lerr));
    if (v.exp_stb != 3'b000) begin
      check({tag, "_acc_adr"}, 64'(a1), 64'(v.adr));
      check({tag, "_acc_dat"}, 64'(d1), 64'(v.wdat));
      check({tag, "_acc_sel"}, 64'(s1), 64'(v.we ? 4'h5 : 4'hF));
      check({tag, "_acc_we"}, 64'(w1), 64'(v.we ? v.exp_stb : 3'b000));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(wb_ack), 64'd0);
    check({tag, "_err"}, 64'(wb_err), 64'd0);
    check({tag, "_rdat"}, 64'(wb_rdat), 64'd0);
    check({tag, "_acc_cyc"}, 64'(acc_cyc), 64'd0);
    check({tag, "_acc_stb"}, 64'(acc_stb), 64'd0);
    check({tag, "_acc_we"}, 64'(acc_we), 64'd0);
    check({tag, "_acc_adr_or"}, 64'(|acc_adr), 64'd0);
    check({tag, "_acc_dat_or"}, 64'(|acc_wdat), 64'd0);
    check({tag, "_acc_sel"}, 64'(acc_sel), 64'd0);
    check({tag, "_tcnt"}, 64'(tcnt), 64'd0);
    check({tag, "_lerr"}, 64'(lerr), 64'd0);
  endtask

  // Watch n cycles and report whether any response appeared.
  task automatic quiet_cycles(input int n, output logic any_resp);
    any_resp = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (wb_ack || wb_err) any_resp = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    logic ga, ge, resp; logic [31:0] gd, a1, d1; logic [3:0] s1; logic [2:0] st1, w1;
    int gc, cc, missing;

    //          adr           we    wdat          sl dl kind   rdata         stray   ack   err   dat           cy stb     tcnt   lerr
    vecs[0] = '{32'h0000_1004, 1'b0, 32'h0000_0000, 1, 0, 2'b01, 32'hCAFE_0001, 3'b000, 1'b1, 1'b0, 32'hCAFE_0001, 2, 3'b010, 8'd0, 32'h0000_0000};
    vecs[1] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 0, 2, 2'b01, 32'hA5A5_A5A5, 3'b000, 1'b1, 1'b0, 32'hA5A5_A5A5, 4, 3'b001, 8'd0, 32'h0000_0000};
    vecs[2] = '{32'h0000_2008, 1'b0, 32'h0000_0000, 2, 1, 2'b10, 32'h7777_7777, 3'b000, 1'b0, 1'b1, 32'h0000_0000, 3, 3'b100, 8'd0, 32'h0000_2008};
    vecs[3] = '{32'h0000_3000, 1'b1, 32'h0000_0055, 0, 0, 2'b00, 32'h0000_0000, 3'b000, 1'b0, 1'b1, 32'h0000_0000, 1, 3'b000, 8'd0, 32'h0000_3000};
    vecs[4] = '{32'h0001_0000, 1'b0, 32'h0000_0000, 0, 0, 2'b00, 32'h0000_0000, 3'b000, 1'b0, 1'b1, 32'h0000_0000, 1, 3'b000, 8'd0, 32'h0001_0000};
    vecs[5] = '{32'h0000_1040, 1'b0, 32'h0000_0000, 1, 0, 2'b11, 32'h0000_0099, 3'b000, 1'b0, 1'b1, 32'h0000_0000, 2, 3'b010, 8'd0, 32'h0000_1040};
    vecs[6] = '{32'h0000_1000, 1'b0, 32'h0000_0000, 1, 2, 2'b01, 32'h1111_2222, 3'b001, 1'b1, 1'b0, 32'h1111_2222, 4, 3'b010, 8'd0, 32'h0000_1040};
    vecs[7] = '{32'h0000_0020, 1'b0, 32'h0000_0000, 0, 0, 2'b00, 32'h0000_0000, 3'b000, 1'b0, 1'b1, 32'h0000_0000, 9, 3'b001, 8'd1, 32'h0000_0020};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Master drops cyc in the third ACCESS cycle.
    @(posedge clk); #1;
    wb_adr = 32'h0000_0000; wb_cyc = 1'b1; wb_stb = 1'b1; wb_sel = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
    end
    check("drop_cyc_before", 64'(acc_cyc), 64'(3'b001));
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    check("drop_cyc_after", 64'(acc_cyc), 64'd0);
    check("drop_resp_now", 64'(wb_ack | wb_err), 64'd0);
    quiet_cycles(12, resp);
    check("drop_no_resp", 64'(resp), 64'd0);
    check("drop_tcnt", 64'(tcnt), 64'd1);
    v = vecs[0]; v.exp_tcnt = 8'd1; v.exp_lerr = 32'h0000_0020;
    apply_vec(v, "after_drop");

    // Saturate the timeout counter.
    missing = 0;
    for (int i = 0; i < 300; i++) begin
      run_access(vecs[7], ga, ge, gd, gc, st1, a1, d1, s1, w1, cc);
      if (!(ge && !ga && gc == 9)) missing++;
    end
    check("sat_bad_timeouts", 64'(missing), 64'd0);
    check("sat_tcnt", 64'(tcnt), 64'd255);

    // Reset for one cycle in the middle of an access.
    @(posedge clk); #1;
    wb_adr = 32'h0000_0004; wb_cyc = 1'b1; wb_stb = 1'b1; wb_sel = 4'hF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("midrst_cyc_before", 64'(acc_cyc), 64'(3'b001));
    rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst_n = 1'b1;
    quiet_cycles(12, resp);
    check("midrst_no_resp", 64'(resp), 64'd0);

    // Back-to-back: strobe held through the response starts the next request.
    acc_ack = 3'b111;
    acc_rdat = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    @(posedge clk); #1;
    wb_adr = 32'h0000_1004; wb_cyc = 1'b1; wb_stb = 1'b1; wb_sel = 4'hF; wb_we = 1'b0;
    @(posedge clk); #1;
    check("b2b_stb1", 64'(acc_stb), 64'(3'b010));
    @(posedge clk); #1;
    check("b2b_ack1", 64'({wb_ack, wb_err}), 64'(2'b10));
    check("b2b_dat1", 64'(wb_rdat), 64'(32'hC1C1_0001));
    wb_adr = 32'h0000_2000;
    @(posedge clk); #1;
    check("b2b_gap", 64'({wb_ack, wb_err, acc_stb}), 64'd0);
    @(posedge clk); #1;
    check("b2b_stb2", 64'(acc_stb), 64'(3'b100));
    @(posedge clk); #1;
    check("b2b_ack2", 64'({wb_ack, wb_err}), 64'(2'b10));
    check("b2b_dat2", 64'(wb_rdat), 64'(32'hC2C2_0002));
    idle_inputs();
    @(posedge clk); #1;
    check("b2b_tcnt", 64'(tcnt), 64'd0);
    check("b2b_lerr", 64'(lerr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
